seg_capture: RTL and testbench
==============================

# seg_capture

Receive side of the multiplexed four-digit seven-segment bus: samples the active-low anode and segment lines, decodes each glyph back to a 4-bit hex digit and rebuilds the 16-bit displayed value. Used as an on-board loopback/monitor: the display driver's D0_AN/D0_SEG outputs feed this block, and its value drives led for self-check. Tolerates the asynchronous or glitchy bus through input synchronisation plus a stability filter, and flags invalid glyphs and a stalled scan.

## Interface
- SETTLE_CYCLES, 4: consecutive cycles the synchronised anode and segment lines must hold before a digit is captured; legal range 1..255.
- TIMEOUT, 500000: cycles without any capture before the bus is declared stale; legal range 1..2^24-1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- an_in  in  4  anode lines, active low; bit i selects digit i (nibble value[4i+3:4i]).
- seg_in  in  8  segments, active low; bit 7 = decimal point, bits 6:0 = g..a.
- value  out  16  last captured digit per position.
- digit_valid  out  4  bit i set when value[4i+3:4i] holds a good, non-stale capture.
- frame_valid  out  1  AND of digit_valid.
- frame_strobe  out  1  one-cycle pulse when all four positions captured since last pulse.
- bad_seg  out  1  one-cycle pulse on an undecodable glyph.
- stale  out  1  high when TIMEOUT cycles have passed with no capture.

## Operation
- an_in and seg_in pass through a 2-flop synchroniser; all logic below uses the synchronised copies (an_s, seg_s).
- Anode classification: exactly one zero bit -> active digit i; 4'b1111 -> blank; any other pattern -> invalid. Blank and invalid never capture.
- Stability counter: cleared whenever {an_s, seg_s} differs from the previous cycle; otherwise increments, saturating at SETTLE_CYCLES.
- Capture event: counter reaches SETTLE_CYCLES with an_s single-active and the per-activation captured flag clear. The flag sets on capture and clears on any change of an_s, so one activation yields exactly one capture.
- Glyph decode: the exact inverse of the team hex encoder on seg_s[6:0]: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x18->9, 0x08->A, 0x03->b, 0x46->C, 0x21->d, 0x06->E, 0x0E->F. Any other pattern, including blank 0x7F, is invalid.
- Valid glyph at capture: value nibble i updated, digit_valid[i] set, seen[i] set, timeout counter cleared.
- Invalid glyph at capture: bad_seg pulses, nibble i retained, digit_valid[i] cleared, seen[i] untouched, timeout counter not cleared.
- Frame: when seen becomes 4'b1111, frame_strobe pulses in the same cycle the last nibble updates, and seen clears to 0.
- Timeout: counter increments every cycle and saturates at TIMEOUT. On reaching TIMEOUT, stale sets and digit_valid and seen clear; value is retained. The next valid capture clears stale.

## Timing
- Reset: value 16'h0000, digit_valid 0, frame_valid 0, frame_strobe 0, bad_seg 0, stale 0; synchroniser, counters, seen and captured flag all cleared. Reset mid-activation discards any partial stability count.
- Latency: inputs stable before edge 0 -> value/digit_valid/bad_seg/frame_strobe registered at edge SETTLE_CYCLES+2.
- All outputs are registered; pulses are exactly one cycle wide.
- Capture and timeout in the same cycle: the capture wins, the counter clears and stale stays 0.
- Glitch shorter than SETTLE_CYCLES: no capture. An anode glitch clears the captured flag, allowing a re-capture of the same digit.

## Configuration
- SEG_CAPTURE_DP_EN defined: bit 7 is checked; a lit decimal point (seg_s[7]=0) makes the glyph invalid (bad_seg, no update).
- Undefined: bit 7 is ignored entirely.

## Test plan
- After reset, hold an_in=4'b1110, seg_in=8'hA4 -> at edge SETTLE_CYCLES+2, value=16'h0002, digit_valid=4'b0001, single capture only.
- Scan digits 0..3 with glyphs F,E,E,B (0x8E,0x86,0x86,0x83), 10 cycles each -> value=16'hBEEF, one frame_strobe on digit 3 capture, frame_valid=1.
- an_in=4'b1101, seg_in=8'hFF (blank) -> bad_seg pulse, digit_valid[1] cleared, value unchanged.
- seg_in held, an_in glitch 4'b1011 for 2 cycles with SETTLE_CYCLES=4 -> no capture; an_in=4'b1100 -> never captures.
- Stop scanning with TIMEOUT=100 -> stale=1 and digit_valid=0 after 100 cycles; the next valid capture clears stale.
- Build with SEG_CAPTURE_DP_EN, seg_in=8'h24 on digit 0 -> bad_seg; without the macro -> value[3:0]=2.

Source files
------------

// File: rtl/seg_capture_if.sv
// Seven-segment monitor bus: raw active-low anode/segment lines in, rebuilt value and status out.
// The master drives the display lines; the slave is the capture block.
interface seg_capture_if;
  logic [3:0]  an_in;
  logic [7:0]  seg_in;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        frame_strobe;
  logic        bad_seg;
  logic        stale;

  modport master (
    output an_in, seg_in,
    input  value, digit_valid, frame_valid, frame_strobe, bad_seg, stale
  );

  modport slave (
    input  an_in, seg_in,
    output value, digit_valid, frame_valid, frame_strobe, bad_seg, stale
  );
endinterface

// File: rtl/seg_capture.sv
// Decodes a multiplexed 4-digit seven-segment bus back to a 16-bit value; SEG_CAPTURE_DP_EN rejects lit DPs.
// Latency: SETTLE_CYCLES+2 edges from stable inputs to registered outputs; no backpressure (pure monitor).
module seg_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 500000
) (
  input  logic        clk,
  input  logic        rst,
  seg_capture_if.slave bus
);
  localparam logic [7:0]  SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [23:0] TMO    = 24'(TIMEOUT);

  logic [3:0]  an_m_q, an_s_q, an_p_q;
  logic [7:0]  seg_m_q, seg_s_q, seg_p_q;
  logic [7:0]  stab_q, stab_d;
  logic        captured_q, captured_d;
  logic [23:0] tmo_q, tmo_d, tmo_inc;
  logic [15:0] value_q, value_d;
  logic [3:0]  dv_q, dv_d, seen_q, seen_d, seen_nx;
  logic        fv_q, fs_q, fs_d, bad_q, bad_d, stale_q, stale_d;
  logic        single;
  logic [1:0]  idx;
  logic        cap, glyph_ok, cap_ok;
  logic [3:0]  nib;

  function automatic logic [4:0] decode(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h40: r = 5'h10; 7'h79: r = 5'h11; 7'h24: r = 5'h12; 7'h30: r = 5'h13;
      7'h19: r = 5'h14; 7'h12: r = 5'h15; 7'h02: r = 5'h16; 7'h78: r = 5'h17;
      7'h00: r = 5'h18; 7'h18: r = 5'h19; 7'h08: r = 5'h1A; 7'h03: r = 5'h1B;
      7'h46: r = 5'h1C; 7'h21: r = 5'h1D; 7'h06: r = 5'h1E; 7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    single = 1'b1;
    idx    = 2'd0;
    case (an_s_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    if ({an_s_q, seg_s_q} != {an_p_q, seg_p_q}) stab_d = 8'd0;
    else if (stab_q == SETTLE)                   stab_d = stab_q;
    else                                         stab_d = stab_q + 8'd1;

    cap = single && (stab_d == SETTLE) && !captured_q;
    {glyph_ok, nib} = decode(seg_s_q[6:0]);
`ifdef SEG_CAPTURE_DP_EN
    if (!seg_s_q[7]) glyph_ok = 1'b0;
`endif
    cap_ok = cap && glyph_ok;

    // An anode change starts a new activation, so the one-shot flag re-arms.
    if (an_s_q != an_p_q) captured_d = 1'b0;
    else if (cap)         captured_d = 1'b1;
    else                  captured_d = captured_q;

    tmo_inc = (tmo_q == TMO) ? tmo_q : tmo_q + 24'd1;
    tmo_d   = cap_ok ? 24'd0 : tmo_inc;

    value_d = value_q;
    dv_d    = dv_q;
    seen_d  = seen_q;
    seen_nx = seen_q | (4'b0001 << idx);
    fs_d    = 1'b0;
    bad_d   = 1'b0;
    stale_d = stale_q;

    if (cap_ok) begin
      value_d[{idx, 2'b00} +: 4] = nib;
      dv_d[idx] = 1'b1;
      stale_d   = 1'b0;
      if (seen_nx == 4'hF) begin
        fs_d   = 1'b1;
        seen_d = 4'h0;
      end else begin
        seen_d = seen_nx;
      end
    end else if (cap) begin
      bad_d     = 1'b1;
      dv_d[idx] = 1'b0;
    end

    // A valid capture clears the counter, so it always beats a coincident timeout.
    if (!cap_ok && tmo_inc == TMO) begin
      stale_d = 1'b1;
      dv_d    = 4'h0;
      seen_d  = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_m_q     <= 4'h0;
      an_s_q     <= 4'h0;
      an_p_q     <= 4'h0;
      seg_m_q    <= 8'h00;
      seg_s_q    <= 8'h00;
      seg_p_q    <= 8'h00;
      stab_q     <= 8'd0;
      captured_q <= 1'b0;
      tmo_q      <= 24'd0;
      value_q    <= 16'h0000;
      dv_q       <= 4'h0;
      seen_q     <= 4'h0;
      fv_q       <= 1'b0;
      fs_q       <= 1'b0;
      bad_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      an_m_q     <= bus.an_in;
      an_s_q     <= an_m_q;
      an_p_q     <= an_s_q;
      seg_m_q    <= bus.seg_in;
      seg_s_q    <= seg_m_q;
      seg_p_q    <= seg_s_q;
      stab_q     <= stab_d;
      captured_q <= captured_d;
      tmo_q      <= tmo_d;
      value_q    <= value_d;
      dv_q       <= dv_d;
      seen_q     <= seen_d;
      fv_q       <= &dv_d;
      fs_q       <= fs_d;
      bad_q      <= bad_d;
      stale_q    <= stale_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.digit_valid  = dv_q;
  assign bus.frame_valid  = fv_q;
  assign bus.frame_strobe = fs_q;
  assign bus.bad_seg      = bad_q;
  assign bus.stale        = stale_q;
endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: cycle model built from the glyph table plus directed literal checks.
module tb_seg_capture;
  localparam int S = 4;
  localparam int T = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_capture_if bus();

  seg_capture #(.SETTLE_CYCLES(S), .TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Encoder table; the model decodes by searching it.
  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  m_s1_an = 0, m_s2_an = 0, m_last_an = 0;
  logic [7:0]  m_s1_seg = 0, m_s2_seg = 0, m_last_seg = 0;
  int          m_hold = 1;
  int          m_tmo = 0;
  logic        m_capd = 0;
  logic [15:0] m_value = 0;
  logic [3:0]  m_dv = 0, m_seen = 0;
  logic        m_fv = 0, m_fs = 0, m_bad = 0, m_stale = 0;

  always @(posedge clk) begin
    logic ok, good;
    logic [3:0] nib;
    int di;
    if (rst) begin
      m_s1_an = 0; m_s2_an = 0; m_last_an = 0;
      m_s1_seg = 0; m_s2_seg = 0; m_last_seg = 0;
      m_hold = 1; m_tmo = 0; m_capd = 0;
      m_value = 0; m_dv = 0; m_seen = 0;
      m_fv = 0; m_fs = 0; m_bad = 0; m_stale = 0;
    end else begin
      if (m_s2_an == m_last_an && m_s2_seg == m_last_seg) m_hold++;
      else m_hold = 1;
      if (m_s2_an != m_last_an) m_capd = 0;
      m_last_an = m_s2_an;
      m_last_seg = m_s2_seg;
      m_fs = 0; m_bad = 0; good = 0;
      if (m_tmo < T) m_tmo++;
      if ($countones(~m_s2_an) == 1 && m_hold > S && !m_capd) begin
        m_capd = 1;
        di = 0;
        for (int i = 0; i < 4; i++) if (!m_s2_an[i]) di = i;
        ok = 0; nib = 0;
        for (int g = 0; g < 16; g++) begin
          if (enc[g] == m_s2_seg[6:0]) begin
            ok = 1;
            nib = 4'(g);
          end
        end
`ifdef SEG_CAPTURE_DP_EN
        if (!m_s2_seg[7]) ok = 0;
`endif
        if (ok) begin
          good = 1;
          m_value[4*di +: 4] = nib;
          m_dv[di] = 1;
          m_seen[di] = 1;
          m_tmo = 0;
          m_stale = 0;
          if (m_seen == 4'hF) begin
            m_fs = 1;
            m_seen = 0;
          end
        end else begin
          m_bad = 1;
          m_dv[di] = 0;
        end
      end
      if (!good && m_tmo == T) begin
        m_stale = 1; m_dv = 0; m_seen = 0;
      end
      m_fv = &m_dv;
    end
    if (rst) begin
      m_s2_an = 0; m_s2_seg = 0; m_s1_an = 0; m_s1_seg = 0;
    end else begin
      m_s2_an = m_s1_an; m_s2_seg = m_s1_seg;
      m_s1_an = bus.an_in; m_s1_seg = bus.seg_in;
    end
  end

  int fs_cnt = 0;
  int bad_cnt = 0;

  always @(negedge clk) begin
    chk("cyc_value", 32'(bus.value), 32'(m_value));
    chk("cyc_digit_valid", 32'(bus.digit_valid), 32'(m_dv));
    chk("cyc_frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    chk("cyc_frame_strobe", 32'(bus.frame_strobe), 32'(m_fs));
    chk("cyc_bad_seg", 32'(bus.bad_seg), 32'(m_bad));
    chk("cyc_stale", 32'(bus.stale), 32'(m_stale));
    if (!rst && bus.frame_strobe) fs_cnt++;
    if (!rst && bus.bad_seg) bad_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    bus.an_in = a;
    bus.seg_in = s;
    step(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  logic [7:0] scan_glyph [4] = '{8'h8E, 8'h86, 8'h86, 8'h83};
  int bad_before;

  initial begin
    bus.an_in = 4'b1110;
    bus.seg_in = 8'hA4;
    do_reset();
    chk("reset_value", 32'(bus.value), 32'h0);
    chk("reset_dv", 32'(bus.digit_valid), 32'h0);
    chk("reset_stale", 32'(bus.stale), 32'h0);

    // Digit 0 shows "2": capture lands on edge S+2 after release.
    step(S + 2);
    chk("lat_dv_early", 32'(bus.digit_valid), 32'h0);
    step(1);
    chk("lat_value", 32'(bus.value), 32'h0002);
    chk("lat_dv", 32'(bus.digit_valid), 32'h1);
    step(10);
    chk("lat_no_bad", 32'(bad_cnt), 32'd0);

    drive(4'b1111, 8'hFF, 6);
    for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), scan_glyph[d], 10);
    drive(4'b1111, 8'hFF, 4);
    chk("scan_value", 32'(bus.value), 32'hBEEF);
    chk("scan_frame_valid", 32'(bus.frame_valid), 32'h1);
    chk("scan_strobes", 32'(fs_cnt), 32'd1);

    drive(4'b1101, 8'hFF, 10);
    chk("blank_bad_cnt", 32'(bad_cnt), 32'd1);
    chk("blank_dv", 32'(bus.digit_valid), 32'hD);
    chk("blank_value", 32'(bus.value), 32'hBEEF);

    drive(4'b1110, 8'hC0, 10);
    drive(4'b1011, 8'hC0, 2);
    drive(4'b1110, 8'hC0, 10);
    chk("glitch_value", 32'(bus.value), 32'hBEE0);
    chk("glitch_dv", 32'(bus.digit_valid), 32'hD);
    drive(4'b1100, 8'hF9, 20);
    chk("multi_an_value", 32'(bus.value), 32'hBEE0);
    chk("multi_an_bad", 32'(bad_cnt), 32'd1);

    drive(4'b1111, 8'hFF, 110);
    chk("tmo_stale", 32'(bus.stale), 32'h1);
    chk("tmo_dv", 32'(bus.digit_valid), 32'h0);
    chk("tmo_value", 32'(bus.value), 32'hBEE0);
    drive(4'b1101, 8'hF9, 10);
    chk("tmo_clear_stale", 32'(bus.stale), 32'h0);
    chk("tmo_clear_dv", 32'(bus.digit_valid), 32'h2);
    chk("tmo_clear_value", 32'(bus.value), 32'hBE10);

    // Capture timed to land on the exact edge the timeout would fire.
    bus.an_in = 4'b1111;
    bus.seg_in = 8'hFF;
    do_reset();
    chk("reset2_value", 32'(bus.value), 32'h0);
    step(93);
    drive(4'b1110, 8'hC0, 6);
    chk("race_pre_dv", 32'(bus.digit_valid), 32'h0);
    chk("race_pre_stale", 32'(bus.stale), 32'h0);
    step(1);
    chk("race_dv", 32'(bus.digit_valid), 32'h1);
    chk("race_stale", 32'(bus.stale), 32'h0);
    step(5);
    chk("race_stale_after", 32'(bus.stale), 32'h0);

    bus.an_in = 4'b1110;
    bus.seg_in = 8'h24;
    do_reset();
    bad_before = bad_cnt;
    step(10);
`ifdef SEG_CAPTURE_DP_EN
    chk("dp_bad", 32'(bad_cnt - bad_before), 32'd1);
    chk("dp_value", 32'(bus.value), 32'h0);
`else
    chk("dp_bad", 32'(bad_cnt - bad_before), 32'd0);
    chk("dp_value", 32'(bus.value), 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
